mul_unit: RTL and testbench

MUL_UNIT -- requirements
Module: mul_unit

---
 rtl/mul_unit_if.sv | 12 +
 rtl/mul_unit.sv | 58 +++++
 tb/tb_mul_unit.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/mul_unit_if.sv
// Issue/result bundle for mul_unit: operands and op select in, registered result and valid out.
interface mul_unit_if;
    logic        en;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  mulctl;
    logic [31:0] mulres;
    logic        valid;

    modport master (output en, a, b, mulctl, input mulres, valid);
    modport slave  (input en, a, b, mulctl, output mulres, valid);
endinterface

// File: rtl/mul_unit.sv
// Two-cycle, fully pipelined RV32M multiplier (MUL/MULH/MULHSU/MULHU).
// Define MUL_UNIT_HOLD_RESULT_EN to hold mulres between valid pulses; otherwise it reads 0.
module mul_unit (
    input  logic       clk,
    input  logic       rst,
    mul_unit_if.slave  bus
);
    localparam int STAGES = 2;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  ctl;
    } req_t;

    req_t              s1;
    logic [1:0]        ctl2;
    logic [63:0]       prod2;
    logic [31:0]       mulres_q;
    logic [STAGES:0]   vld_pipe;

    logic              sa, sb;
    logic [63:0]       ea, eb, prod;
    logic [31:0]       res2;

    // Extending straight to 64 bits matches the 33-bit extension; low 64 product bits are exact.
    always_comb begin
        sa   = (s1.ctl == 2'b01) || (s1.ctl == 2'b10);
        sb   = (s1.ctl == 2'b01);
        ea   = {{32{sa & s1.a[31]}}, s1.a};
        eb   = {{32{sb & s1.b[31]}}, s1.b};
        prod = ea * eb;
        res2 = (ctl2 == 2'b00) ? prod2[31:0] : prod2[63:32];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            s1       <= '0;
            ctl2     <= '0;
            prod2    <= '0;
            mulres_q <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:0], bus.en};
            if (bus.en) s1 <= '{a: bus.a, b: bus.b, ctl: bus.mulctl};
            ctl2  <= s1.ctl;
            prod2 <= prod;
`ifdef MUL_UNIT_HOLD_RESULT_EN
            if (vld_pipe[STAGES-1]) mulres_q <= res2;
`else
            mulres_q <= vld_pipe[STAGES-1] ? res2 : 32'h0;
`endif
        end
    end

    assign bus.mulres = mulres_q;
    assign bus.valid  = vld_pipe[STAGES];
endmodule

// File: tb/tb_mul_unit.sv
// Directed self-checking bench for mul_unit; expected values are hand-computed constants.
module tb_mul_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    mul_unit_if bus();
    mul_unit dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] ctl);
        bus.en = en; bus.a = a; bus.b = b; bus.mulctl = ctl;
    endtask

    task automatic test_reset();
        drive(1'b0, 32'h0, 32'h0, 2'b00);
        rst = 1'b1;
        repeat (3) tick();
        n_checks++;
        if (bus.valid !== 1'b0 || bus.mulres !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_state: valid=%b mulres=%h, want 0/0", bus.valid, bus.mulres);
        end
        rst = 1'b0;
    endtask

    // Single MUL: result at edge k+2, valid for one cycle only.
    task automatic test_mul_basic();
        drive(1'b1, 32'd16, 32'd48, 2'b00);
        tick();
        drive(1'b0, 32'h0, 32'h0, 2'b00);
        tick();
        n_checks++;
        if (bus.valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_early: valid=%b at k+1, want 0", bus.valid);
        end
        tick();
        n_checks++;
        if (bus.valid !== 1'b1 || bus.mulres !== 32'd768) begin
            n_fail++;
            $display("FAIL basic_mul: valid=%b mulres=%0d, want 1/768", bus.valid, bus.mulres);
        end
        tick();
        n_checks++;
        if (bus.valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_pulse: valid=%b at k+3, want 0", bus.valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0]  ctl [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
        logic [31:0] exp [4] = '{32'd12, 32'h0, 32'hFFFFFFFD, 32'hFFFFFFF9};
        for (int c = 0; c < 6; c++) begin
            if (c < 4) drive(1'b1, 32'hFFFFFFFD, 32'hFFFFFFFC, ctl[c]);
            else       drive(1'b0, 32'h0, 32'h0, 2'b00);
            tick();
            if (c >= 2) begin
                n_checks++;
                if (bus.valid !== 1'b1 || bus.mulres !== exp[c-2]) begin
                    n_fail++;
                    $display("FAIL b2b_op%0d: valid=%b mulres=%h, want 1/%h",
                             c-2, bus.valid, bus.mulres, exp[c-2]);
                end
            end
        end
        tick();
        n_checks++;
        if (bus.valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_tail: valid=%b, want 0", bus.valid);
        end
    endtask

    // Sign-extension corners, issued back-to-back.
    task automatic test_boundary();
        logic [31:0] va  [14] = '{32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000,
                                  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                  32'h0, 32'h0, 32'd7, 32'd7, 32'd7, 32'd7};
        logic [31:0] vb  [14] = '{32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000,
                                  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                  32'hFFFFFFFF, 32'hFFFFFFFF,
                                  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [1:0]  vc  [14] = '{2'b01, 2'b10, 2'b11, 2'b00,
                                  2'b00, 2'b01, 2'b10, 2'b11,
                                  2'b00, 2'b10,
                                  2'b00, 2'b01, 2'b10, 2'b11};
        logic [31:0] exp [14] = '{32'h40000000, 32'hC0000000, 32'h40000000, 32'h0,
                                  32'h1, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFE,
                                  32'h0, 32'h0,
                                  32'hFFFFFFF9, 32'hFFFFFFFF, 32'h6, 32'h6};
        for (int c = 0; c < 16; c++) begin
            if (c < 14) drive(1'b1, va[c], vb[c], vc[c]);
            else        drive(1'b0, 32'h0, 32'h0, 2'b00);
            tick();
            if (c >= 2) begin
                n_checks++;
                if (bus.valid !== 1'b1 || bus.mulres !== exp[c-2]) begin
                    n_fail++;
                    $display("FAIL bound_op%0d: valid=%b mulres=%h, want 1/%h",
                             c-2, bus.valid, bus.mulres, exp[c-2]);
                end
            end
        end
        tick();
    endtask

    // Reset with two ops in flight; en during reset must be ignored.
    task automatic test_reset_inflight();
        drive(1'b1, 32'd2, 32'd3, 2'b00); tick();
        drive(1'b1, 32'd4, 32'd5, 2'b00); tick();
        drive(1'b1, 32'd6, 32'd7, 2'b00); tick();
        n_checks++;
        if (bus.valid !== 1'b1 || bus.mulres !== 32'd6) begin
            n_fail++;
            $display("FAIL rst_first: valid=%b mulres=%0d, want 1/6", bus.valid, bus.mulres);
        end
        rst = 1'b1;
        drive(1'b1, 32'd9, 32'd9, 2'b00);
        tick();
        rst = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 2'b00);
        n_checks++;
        if (bus.valid !== 1'b0 || bus.mulres !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_clear: valid=%b mulres=%h, want 0/0", bus.valid, bus.mulres);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++;
            if (bus.valid !== 1'b0 || bus.mulres !== 32'h0) begin
                n_fail++;
                $display("FAIL rst_discard%0d: valid=%b mulres=%h, want 0/0",
                         c, bus.valid, bus.mulres);
            end
        end
        drive(1'b1, 32'd11, 32'd13, 2'b00); tick();
        drive(1'b0, 32'h0, 32'h0, 2'b00);   tick(); tick();
        n_checks++;
        if (bus.valid !== 1'b1 || bus.mulres !== 32'd143) begin
            n_fail++;
            $display("FAIL rst_first_after: valid=%b mulres=%0d, want 1/143", bus.valid, bus.mulres);
        end
    endtask

    // mulctl changes after issue must not affect the result; idle gap behaviour.
    task automatic test_idle();
        logic [31:0] idle_exp;
        drive(1'b1, 32'hFFFFFFFF, 32'h2, 2'b11); tick();
        drive(1'b0, 32'h5, 32'h5, 2'b00);       tick(); tick();
        n_checks++;
        if (bus.valid !== 1'b1 || bus.mulres !== 32'h1) begin
            n_fail++;
            $display("FAIL ctl_travel: valid=%b mulres=%h, want 1/00000001", bus.valid, bus.mulres);
        end
`ifdef MUL_UNIT_HOLD_RESULT_EN
        idle_exp = 32'h1;
`else
        idle_exp = 32'h0;
`endif
        for (int c = 0; c < 4; c++) begin
            tick();
            n_checks++;
            if (bus.valid !== 1'b0 || bus.mulres !== idle_exp) begin
                n_fail++;
                $display("FAIL idle%0d: valid=%b mulres=%h, want 0/%h",
                         c, bus.valid, bus.mulres, idle_exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mul_basic();
        test_back_to_back();
        test_boundary();
        test_reset_inflight();
        test_idle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
